mmio_bus_ctrl: RTL and testbench
================================

Name: mmio_bus_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the `proc` bus (`ADDR`/`DOUT`/`W`/`DIN`) and the board.
- Decodes the top two address bits into four regions: RAM, output-register bank, synchronised input port, reserved.
- Aligns read data with the one-cycle synchronous RAM latency and generates the processor `Run` signal from a switch.
- Replaces the ad-hoc `wren`/`len` decode and the single LED register in the top level.

Parameters:
- DATA_W, 9, bus data width.
- ADDR_W, 9, processor address width (minimum RAM_AW+2).
- RAM_AW, 7, RAM address width (RAM depth 2**RAM_AW).
- N_OUT, 2, number of output registers (>=1); IW = max(1, $clog2(N_OUT)).
- RUN_MODE, 0, 0 = Run follows synced switch level; 1 = Run is a 1-cycle pulse on the synced switch rising edge.

Ports:
- Clock  in  1  system clock; all state on its rising edge.
- Resetn  in  1  asynchronous, active-high reset (asserted = 1).
- ADDR  in  ADDR_W  processor address.
- DOUT  in  DATA_W  processor write data.
- W  in  1  processor write strobe.
- DIN  out  DATA_W  read data returned to processor.
- ram_addr  out  RAM_AW  = ADDR[RAM_AW-1:0], combinational.
- ram_data  out  DATA_W  = DOUT, combinational.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM registered read data.
- sw_in  in  DATA_W  asynchronous switch inputs.
- run_sw  in  1  asynchronous run switch.
- Run  out  1  processor run control.
- out_q  out  N_OUT*DATA_W  output registers, register k at bits [k*DATA_W +: DATA_W].
- bad_access  out  1  sticky error flag.

Behaviour:
- Region decoding: rgn = ADDR[ADDR_W-1:ADDR_W-2]. 00 = RAM, 01 = output bank, 10 = input port, 11 = reserved.
- Output-bank index: idx = ADDR[IW-1:0]; bits between IW and ADDR_W-3 are ignored (aliasing).
- RAM writes: ram_wren = W & (rgn==00), combinational.
- Output-register writes: when W & rgn==01 & idx<N_OUT, out_q[idx] <= DOUT at the next edge and is visible the following cycle.
- Out-of-range index: W & rgn==01 & idx>=N_OUT writes nothing and sets bad_access.
- Input synchroniser: sw_in and run_sw each pass through 2 flops (sw_s, run_s), giving 2 cycles of latency.
- Read path, one-cycle latency for every region:
  - Each cycle, sel_q <= rgn and rd_q <= the I/O source: out_q[idx] for 01 (0 if idx>=N_OUT), sw_s for 10, 0 for 11.
  - DIN = (sel_q==00) ? ram_q : rd_q.
  - Data for an address presented in cycle t appears on DIN in cycle t+1, identical to RAM timing.
- Read/write collision: a write to output register k in cycle t and a read of k in cycle t return the old value at t+1; a read in cycle t+1 returns the new value at t+2 (no bypass).
- Reserved region:
  - Any access with W=1 and rgn==11 sets bad_access.
  - Reads of region 11 return 0 and are not flagged, because the processor drives ADDR continuously.
- Input-port writes: W=1 with rgn==10 is ignored and sets bad_access.
- bad_access clears only on reset.
- Run in RUN_MODE 0: Run = run_s (registered).
- Run in RUN_MODE 1:
  - Run = run_s & ~run_prev, registered; exactly 1 cycle high per rising edge.
  - A held switch produces no further pulses.
- Reset values while Resetn=1: out_q, sw_s, run_s, run_prev, Run, sel_q, rd_q, bad_access = 0; DIN = ram_q (sel_q=00).
- Reset mid-write: the write is lost and registers read 0.
- Release of reset takes effect on the first Clock edge with Resetn=0.
- Reset does not gate ram_wren; the processor holds W low during reset.

Decomposition:
- Package mmio_pkg holds region localparams RGN_RAM=2'b00, RGN_OUT=2'b01, RGN_IN=2'b10, RGN_RSV=2'b11, plus function out_slice(k).
- One sub-module, sync2: a parametrised-width 2-flop synchroniser with async active-high reset, used for sw_in and run_sw.

Test Plan:
- Reset: Resetn=1 for 3 cycles with random inputs -> out_q=0, Run=0, bad_access=0; after release with ADDR=0x000, DIN equals ram_q.
- Output write/readback: W=1, ADDR=0x081, DOUT=0x1A5, then read 0x081 -> out_q[1]=0x1A5 next cycle; DIN=0x1A5 one cycle after read ADDR; out_q[0] unchanged (0).
- RAM decode: W=1, ADDR=0x07F -> ram_wren=1, ram_addr=0x7F; W=1, ADDR=0x080 -> ram_wren=0; a read of 0x010 passes ram_q straight through to DIN.
- Input sync: sw_in=0x155 at cycle t, ADDR=0x100 held -> DIN=0 through t+2, DIN=0x155 at t+3.
- Errors: W=1 to 0x180, then separately W=1 to 0x100 -> bad_access=1 after the first, stays 1 with no out_q change; with N_OUT=3, a write to 0x083 also sets it; a read of 0x180 alone does not.
- Run modes: RUN_MODE=1, run_sw 0->1 held for 10 cycles -> exactly one 1-cycle Run pulse, 3 cycles after the edge; RUN_MODE=0 -> Run high from the 3rd cycle and stays high.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped I/O controller.
//   RGN_*      : region codes taken from the top two address bits.
//   out_slice  : bit offset of output register k inside a flat bus of
//                registers that are w bits wide each.
package mmio_pkg;

  localparam logic [1:0] RGN_RAM = 2'b00;
  localparam logic [1:0] RGN_OUT = 2'b01;
  localparam logic [1:0] RGN_IN  = 2'b10;
  localparam logic [1:0] RGN_RSV = 2'b11;

  function automatic int out_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_sync2.sv
// sync2: two-flop synchroniser for asynchronous inputs, WIDTH bits wide.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears both stages
//   d_i  : asynchronous input
//   q_o  : synchronised output, two clock edges after d_i
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: memory-mapped I/O controller between the processor bus
// and the board. The top two address bits select RAM, an output-register
// bank, a synchronised input port or a reserved region. Every region reads
// back with one cycle of latency so the processor sees uniform timing.
//   Clock, Resetn        : clock and asynchronous active-high reset
//   ADDR, DOUT, W        : processor address, write data, write strobe
//   DIN                  : read data returned to the processor
//   ram_addr/data/wren   : RAM write/address side (combinational)
//   ram_q                : registered RAM read data
//   sw_in, run_sw        : asynchronous board switches
//   Run                  : processor run control (level or pulse)
//   out_q                : output registers, register k at [k*DATA_W +: DATA_W]
//   bad_access           : sticky flag for illegal writes
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int ADDR_W   = 9,
  parameter int RAM_AW   = 7,
  parameter int N_OUT    = 2,
  parameter int RUN_MODE = 0
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       DOUT,
  input  logic                    W,
  output logic [DATA_W-1:0]       DIN,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_data,
  output logic                    ram_wren,
  input  logic [DATA_W-1:0]       ram_q,
  input  logic [DATA_W-1:0]       sw_in,
  input  logic                    run_sw,
  output logic                    Run,
  output logic [N_OUT*DATA_W-1:0] out_q,
  output logic                    bad_access
);

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [1:0]        rgn;
  logic [IW-1:0]     idx;
  logic              idx_ok;
  logic [DATA_W-1:0] out_sel;
  logic              out_wr;

  logic [DATA_W-1:0] out_regs_q [N_OUT];
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              bad_q, bad_d;
  logic              run_prev_q;
  logic              run_q, run_d;

  logic [DATA_W-1:0] sw_s;
  logic              run_s;

  assign rgn = ADDR[ADDR_W-1 -: 2];
  // Bits between IW and the region field are ignored, so registers alias.
  assign idx = ADDR[IW-1:0];

  assign ram_addr = ADDR[RAM_AW-1:0];
  assign ram_data = DOUT;
  // Not gated by reset: the processor holds W low while reset is asserted.
  assign ram_wren = W & (rgn == RGN_RAM);

  sync2 #(.WIDTH(DATA_W)) u_sync_sw (
    .clk (Clock),
    .rst (Resetn),
    .d_i (sw_in),
    .q_o (sw_s)
  );

  sync2 #(.WIDTH(1)) u_sync_run (
    .clk (Clock),
    .rst (Resetn),
    .d_i (run_sw),
    .q_o (run_s)
  );

  always_comb begin
    idx_ok  = 1'b0;
    out_sel = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (idx == IW'(k)) begin
        idx_ok  = 1'b1;
        out_sel = out_regs_q[k];
      end
    end

    case (rgn)
      RGN_OUT: rd_d = out_sel;
      RGN_IN:  rd_d = sw_s;
      default: rd_d = '0;
    endcase

    out_wr = W & (rgn == RGN_OUT) & idx_ok;

    // Only writes are flagged; reads of any region are harmless because
    // the processor drives ADDR continuously.
    bad_d = bad_q | (W & (((rgn == RGN_OUT) & ~idx_ok) |
                          (rgn == RGN_IN) | (rgn == RGN_RSV)));

    run_d = (RUN_MODE == 0) ? run_s : (run_s & ~run_prev_q);
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      for (int k = 0; k < N_OUT; k++) out_regs_q[k] <= '0;
      sel_q      <= RGN_RAM;
      rd_q       <= '0;
      bad_q      <= 1'b0;
      run_prev_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_wr && (idx == IW'(k))) out_regs_q[k] <= DOUT;
      end
      sel_q      <= rgn;
      rd_q       <= rd_d;
      bad_q      <= bad_d;
      run_prev_q <= run_s;
      run_q      <= run_d;
    end
  end

  // RAM data already carries its own one-cycle latency; I/O data is
  // registered here to match it.
  assign DIN        = (sel_q == RGN_RAM) ? ram_q : rd_q;
  assign Run        = run_q;
  assign bad_access = bad_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_flat
    assign out_q[out_slice(g, DATA_W) +: DATA_W] = out_regs_q[g];
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
module tb_mmio_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] addr, dout, ram_q, sw_in;
  logic       w, run_sw;

  logic [8:0]  din0, din1, rdata0, rdata1;
  logic [6:0]  raddr0, raddr1;
  logic        wren0, wren1, run0, run1, bad0, bad1;
  logic [17:0] outq0;
  logic [26:0] outq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl #(.DATA_W(9), .ADDR_W(9), .RAM_AW(7), .N_OUT(2), .RUN_MODE(0)) dut0 (
    .Clock(clk), .Resetn(rst), .ADDR(addr), .DOUT(dout), .W(w), .DIN(din0),
    .ram_addr(raddr0), .ram_data(rdata0), .ram_wren(wren0), .ram_q(ram_q),
    .sw_in(sw_in), .run_sw(run_sw), .Run(run0), .out_q(outq0), .bad_access(bad0)
  );

  mmio_bus_ctrl #(.DATA_W(9), .ADDR_W(9), .RAM_AW(7), .N_OUT(3), .RUN_MODE(1)) dut1 (
    .Clock(clk), .Resetn(rst), .ADDR(addr), .DOUT(dout), .W(w), .DIN(din1),
    .ram_addr(raddr1), .ram_data(rdata1), .ram_wren(wren1), .ram_q(ram_q),
    .sw_in(sw_in), .run_sw(run_sw), .Run(run1), .out_q(outq1), .bad_access(bad1)
  );

  // Reference model: instance 0 has 2 output registers and level Run,
  // instance 1 has 3 output registers and pulsed Run.
  int         nout [2] = '{2, 3};
  int         iwm  [2] = '{1, 2};
  logic [8:0] outm [2][4];
  bit         badm [2];
  bit         rdram[2];
  logic [8:0] rdm  [2];
  // Input samples taken at the last four edges, newest at index 3.
  logic [8:0] swh [4];
  bit         rnh [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) outm[i][k] = '0;
      badm[i] = 0; rdram[i] = 1; rdm[i] = '0;
    end
    for (int k = 0; k < 4; k++) begin swh[k] = '0; rnh[k] = 0; end
  endtask

  task automatic model_edge();
    int rg, ix;
    if (rst) begin
      model_reset();
      return;
    end
    rg = int'(addr[8:7]);
    for (int i = 0; i < 2; i++) begin
      ix = int'(addr) % (1 << iwm[i]);
      rdram[i] = (rg == 0);
      if (rg == 1)      rdm[i] = (ix < nout[i]) ? outm[i][ix] : 9'd0;
      else if (rg == 2) rdm[i] = swh[2];
      else              rdm[i] = 9'd0;
      if (w) begin
        if (rg == 1 && ix < nout[i]) outm[i][ix] = dout;
        if ((rg == 1 && ix >= nout[i]) || rg == 2 || rg == 3) badm[i] = 1;
      end
    end
    for (int k = 0; k < 3; k++) begin swh[k] = swh[k+1]; rnh[k] = rnh[k+1]; end
    swh[3] = sw_in;
    rnh[3] = run_sw;
  endtask

  task automatic check_regs();
    check_eq("out_q0", 64'(outq0), 64'({outm[0][1], outm[0][0]}));
    check_eq("out_q1", 64'(outq1), 64'({outm[1][2], outm[1][1], outm[1][0]}));
    check_eq("bad0", 64'(bad0), 64'(badm[0]));
    check_eq("bad1", 64'(bad1), 64'(badm[1]));
    check_eq("din0", 64'(din0), 64'(rdram[0] ? ram_q : rdm[0]));
    check_eq("din1", 64'(din1), 64'(rdram[1] ? ram_q : rdm[1]));
    check_eq("run0", 64'(run0), 64'(rnh[1]));
    check_eq("run1", 64'(run1), 64'(rnh[1] & ~rnh[0]));
  endtask

  // One bus cycle with the inputs already set: combinational checks,
  // clock edge, model update, registered checks.
  task automatic cycle();
    ram_q = 9'($urandom);
    #1;
    check_eq("ram_addr", 64'(raddr0), 64'(addr[6:0]));
    check_eq("ram_data", 64'(rdata1), 64'(dout));
    check_eq("ram_wren0", 64'(wren0), 64'(w && addr[8:7] == 2'b00));
    check_eq("ram_wren1", 64'(wren1), 64'(w && addr[8:7] == 2'b00));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic bus(input logic wr, input logic [8:0] a, input logic [8:0] d);
    w = wr; addr = a; dout = d;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; w = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  int pulses, pulse_at;

  initial begin
    rst = 1'b1; addr = '0; dout = '0; w = 1'b0; ram_q = '0; sw_in = '0; run_sw = 1'b0;
    model_reset();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      addr = 9'($urandom); dout = 9'($urandom); sw_in = 9'($urandom); run_sw = 1'($urandom);
      cycle();
    end
    check_eq("rst_outq0", 64'(outq0), 64'd0);
    check_eq("rst_run0", 64'(run0), 64'd0);
    check_eq("rst_bad1", 64'(bad1), 64'd0);
    check_eq("rst_din", 64'(din0), 64'(ram_q));
    rst = 1'b0; sw_in = '0; run_sw = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b0, 9'h000, 9'h0);
    check_eq("rel_din", 64'(din1), 64'(ram_q));

    // Output write and readback.
    bus(1'b1, 9'h081, 9'h1A5);
    check_eq("wr_out1", 64'(outq0[17:9]), 64'h1A5);
    check_eq("wr_out0", 64'(outq0[8:0]), 64'h0);
    bus(1'b0, 9'h081, 9'h0);
    check_eq("rd_out1", 64'(din0), 64'h1A5);

    // Collision: write and read of the same register in one cycle.
    bus(1'b1, 9'h080, 9'h0F3);
    check_eq("coll_old", 64'(din0), 64'h0);
    bus(1'b0, 9'h080, 9'h0);
    check_eq("coll_new", 64'(din0), 64'h0F3);

    // RAM decode.
    w = 1'b1; addr = 9'h07F; #1;
    check_eq("ram_wren_7f", 64'(wren0), 64'd1);
    check_eq("ram_addr_7f", 64'(raddr0), 64'h7F);
    cycle();
    w = 1'b1; addr = 9'h080; #1;
    check_eq("ram_wren_80", 64'(wren1), 64'd0);
    cycle();
    bus(1'b0, 9'h010, 9'h0);
    check_eq("ram_pass", 64'(din0), 64'(ram_q));

    // Input synchroniser latency.
    sw_in = 9'h155;
    bus(1'b0, 9'h100, 9'h0);
    check_eq("sync_t1", 64'(din0), 64'h0);
    bus(1'b0, 9'h100, 9'h0);
    check_eq("sync_t2", 64'(din0), 64'h0);
    bus(1'b0, 9'h100, 9'h0);
    check_eq("sync_t3", 64'(din0), 64'h155);

    // Errors.
    do_reset();
    bus(1'b0, 9'h180, 9'h0);
    check_eq("rsv_read", 64'(bad0), 64'd0);
    bus(1'b1, 9'h180, 9'h1FF);
    check_eq("rsv_write", 64'(bad0), 64'd1);
    bus(1'b1, 9'h100, 9'h1FF);
    check_eq("in_write", 64'(bad1), 64'd1);
    check_eq("err_outq", 64'(outq1), 64'd0);
    do_reset();
    bus(1'b1, 9'h083, 9'h0AA);
    check_eq("oob_bad1", 64'(bad1), 64'd1);
    check_eq("oob_bad0", 64'(bad0), 64'd0);
    check_eq("alias0", 64'(outq0[17:9]), 64'h0AA);

    // Run modes.
    run_sw = 1'b0;
    for (int i = 0; i < 4; i++) bus(1'b0, 9'h000, 9'h0);
    run_sw = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int k = 1; k <= 10; k++) begin
      bus(1'b0, 9'h000, 9'h0);
      if (run1) begin pulses++; pulse_at = k; end
      if (k == 2) check_eq("run0_k2", 64'(run0), 64'd0);
      if (k == 3) check_eq("run0_k3", 64'(run0), 64'd1);
    end
    check_eq("run1_pulses", 64'(pulses), 64'd1);
    check_eq("run1_when", 64'(pulse_at), 64'd3);
    check_eq("run0_held", 64'(run0), 64'd1);

    // Randomized traffic, including occasional reset mid-write.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      w = 1'($urandom);
      addr = {2'($urandom), 5'($urandom_range(0, 3) == 0 ? $urandom : 0), 2'($urandom)};
      dout = 9'($urandom);
      if ($urandom_range(0, 3) == 0) sw_in = 9'($urandom);
      if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
